// File: rtl/pulse_stretch_fsm.sv
// Pulse stretcher: each single-cycle event on x becomes a registered level on y held for
// PARAM_HOLD_CYCLES clocks, separated by PARAM_GAP_CYCLES low clocks; one event queues, more drop.
// Optional feature: define PULSE_STRETCH_RETRIGGER_EN for a retriggerable hold.
module pulse_stretch_fsm #(
  parameter int unsigned PARAM_HOLD_CYCLES = 4,
  parameter int unsigned PARAM_GAP_CYCLES  = 2,
  localparam int unsigned MaxCnt = (PARAM_HOLD_CYCLES > PARAM_GAP_CYCLES) ?
                                   PARAM_HOLD_CYCLES : PARAM_GAP_CYCLES,
  localparam int unsigned PARAM_CNT_WIDTH = $clog2(MaxCnt + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y,
  output logic busy,
  output logic dropped
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHold = 2'b01,
    StGap  = 2'b10
  } state_e;

  localparam logic [PARAM_CNT_WIDTH-1:0] HoldLoad = PARAM_CNT_WIDTH'(PARAM_HOLD_CYCLES - 1);
  localparam logic [PARAM_CNT_WIDTH-1:0] GapLoad  =
      (PARAM_GAP_CYCLES == 0) ? '0 : PARAM_CNT_WIDTH'(PARAM_GAP_CYCLES - 1);
  localparam bit HasGap = (PARAM_GAP_CYCLES != 0);
`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit Retrigger = 1'b1;
`else
  localparam bit Retrigger = 1'b0;
`endif

  state_e                     state_q, state_d;
  logic [PARAM_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       pending_q, pending_d;
  logic                       queue_evt;
  logic                       y_comb, busy_comb, dropped_comb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    queue_evt    = 1'b0;
    dropped_comb = 1'b0;
    case (state_q)
      StHold: begin
        if (Retrigger && x) begin
          cnt_d = HoldLoad;
        end else if (cnt_q != '0) begin
          cnt_d     = cnt_q - PARAM_CNT_WIDTH'(1);
          queue_evt = x;
        end else if (HasGap) begin
          state_d   = StGap;
          cnt_d     = GapLoad;
          queue_evt = x;
        end else if (pending_q || x) begin
          // Launch consumes both the queued event and any event on this edge.
          cnt_d     = HoldLoad;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - PARAM_CNT_WIDTH'(1);
          queue_evt = x;
        end else if (pending_q || x) begin
          state_d   = StHold;
          cnt_d     = HoldLoad;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        // Idle, and the unused encoding recovers here.
        pending_d = 1'b0;
        if (x) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
    if (queue_evt) begin
      if (!pending_q) pending_d = 1'b1;
      else            dropped_comb = 1'b1;
    end
  end

  always_comb begin
    y_comb    = (state_q == StHold);
    busy_comb = (state_q == StHold) || (state_q == StGap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      y       <= y_comb;
      busy    <= busy_comb;
      dropped <= dropped_comb;
    end
  end

endmodule
